// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller.
// Holds the FSM state encoding, period defaults and a short-period set.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GREEN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEF_GREEN = 10000;
  localparam int DEF_CLEAR = 100;

  // Short periods for formal runs and quick simulations
  localparam int SIM_GREEN = 5;
  localparam int SIM_CLEAR = 2;

  // Successor of a way index, wrapping at n
  function automatic int next_way(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of i_mask at or after i_start, wrapping.
// Ports: i_mask, i_start in; o_found (any bit set), o_idx (chosen bit) out.
module rr_pick #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [AW-1:0] i_start,
  output logic          o_found,
  output logic [AW-1:0] o_idx
);

  // Walk from the farthest offset back to the nearest,
  // so the nearest set bit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (i_mask[j]) begin
        o_found = 1'b1;
        o_idx   = AW'(j);
      end
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Grants green to one approach at a time, round-robin, with all-red clearance.
// Ports: clock, reset; request/blocked in; green/red/waiting/active/busy out.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS     = 4,
  parameter int GREEN_PERIOD = DEF_GREEN,
  parameter int CLEAR_PERIOD = DEF_CLEAR,
  parameter int CW           = 32,
  localparam int AW          = $clog2(NUM_WAYS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] request,
  input  logic [NUM_WAYS-1:0] blocked,
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] red,
  output logic [NUM_WAYS-1:0] waiting,
  output logic [AW-1:0]       active,
  output logic                busy
);

  state_t              r_state;
  logic [NUM_WAYS-1:0] r_pending;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       r_sel;
  logic [CW-1:0]       r_cnt;

  state_t              w_state_n;
  logic [NUM_WAYS-1:0] w_pending_n;
  logic [NUM_WAYS-1:0] w_clr;
  logic [AW-1:0]       w_ptr_n;
  logic [AW-1:0]       w_sel_n;
  logic [CW-1:0]       w_cnt_n;
  logic [NUM_WAYS-1:0] w_green;

  logic                w_idle_found;
  logic [AW-1:0]       w_idle_idx;
  logic                w_wait_found;
  logic [AW-1:0]       w_wait_idx;
  logic [NUM_WAYS-1:0] w_wait_mask;
  logic [AW-1:0]       w_sel_nxt;

  assign w_sel_nxt   = AW'(next_way(int'(r_sel), NUM_WAYS));
  assign w_wait_mask = r_pending & ~blocked;

  rr_pick #(.N(NUM_WAYS), .AW(AW)) u_pick_idle (
    .i_mask  (r_pending),
    .i_start (r_ptr),
    .o_found (w_idle_found),
    .o_idx   (w_idle_idx)
  );

  // Search starts just past sel so a blocked sel hands over
  // to the next ready way in rotation order.
  rr_pick #(.N(NUM_WAYS), .AW(AW)) u_pick_wait (
    .i_mask  (w_wait_mask),
    .i_start (w_sel_nxt),
    .o_found (w_wait_found),
    .o_idx   (w_wait_idx)
  );

  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_clr     = '0;
    w_green   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_idle_found) begin
          w_sel_n   = w_idle_idx;
          w_state_n = WAIT;
        end
      end
      WAIT: begin
        if (!blocked[r_sel]) begin
          w_state_n    = GREEN;
          w_cnt_n      = CW'(GREEN_PERIOD);
          w_clr[r_sel] = 1'b1;
        end else if (w_wait_found) begin
          w_sel_n = w_wait_idx;
        end
      end
      GREEN: begin
        w_green[r_sel] = 1'b1;
        if (r_cnt == '0) begin
          w_state_n = CLEAR;
          w_cnt_n   = CW'(CLEAR_PERIOD);
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      CLEAR: begin
        if (r_cnt == '0) begin
          w_state_n = IDLE;
          w_ptr_n   = w_sel_nxt;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // A request arriving on the grant cycle re-arms the latch
  assign w_pending_n = (r_pending & ~w_clr) | request;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_pending <= w_pending_n;
      r_ptr     <= w_ptr_n;
      r_sel     <= w_sel_n;
      r_cnt     <= w_cnt_n;
    end
  end

  assign green   = w_green;
  assign red     = ~w_green;
  assign waiting = r_pending;
  assign active  = r_sel;
  assign busy    = (r_state != IDLE);

endmodule
